serial_pattern_tx: RTL and testbench
====================================

SERIAL_PATTERN_TX -- requirements
Module: serial_pattern_tx

Interface
REQ-001 The block SHALL have parameter GAP_CYCLES, default 2: idle cycles inserted after each frame, legal range 0..15.
REQ-002 The block SHALL have parameter PARITY_EN, default 1: 1 appends an even-parity bit after the data, 0 omits it.
REQ-003 The block SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port in_data, input, 16 bits: word to transmit.
REQ-006 The block SHALL have port in_valid, input, 1 bit: in_data is valid.
REQ-007 The block SHALL have port in_ready, output, 1 bit: the block can accept a word.
REQ-008 The block SHALL have port ser_out, output, 1 bit: serial bit stream.
REQ-009 The block SHALL have port ser_valid, output, 1 bit: ser_out carries a frame bit this cycle.
REQ-010 The block SHALL have port ser_last, output, 1 bit: the current bit is the final bit of the frame.
REQ-011 The block SHALL have port busy, output, 1 bit: the FSM is not in IDLE.
REQ-012 The block SHALL have port frame_cnt, output, 8 bits: number of completed frames, modulo 256.

Function
REQ-013 The FSM SHALL have states IDLE, PRE, DATA, PAR and GAP, and no others.
REQ-014 in_ready SHALL be combinational and equal 1 only in IDLE, with no dependence on in_valid.
REQ-015 A word SHALL be accepted on a rising edge where in_valid=1 and in_ready=1; in_data is latched into a 16-bit shift register, and the FSM moves to PRE.
REQ-016 In PRE, the block SHALL emit preamble bits 1, 1, 0 on three consecutive cycles, with ser_valid=1.
REQ-017 The first preamble bit SHALL appear in the cycle immediately after the accept edge, giving a latency of 1 cycle.
REQ-018 In DATA, the block SHALL emit the 16 latched bits MSB first (bit 15 first), one bit per cycle, with ser_valid=1.
REQ-019 In PAR (only when PARITY_EN=1), the block SHALL emit one bit equal to the XOR of the 16 data bits, with ser_valid=1.
REQ-020 ser_last SHALL be 1 only on the parity bit when PARITY_EN=1, or only on data bit 0 when PARITY_EN=0.
REQ-021 Frame length SHALL be 20 cycles when PARITY_EN=1 and 19 cycles when PARITY_EN=0.
REQ-022 frame_cnt SHALL increment by 1 on the edge that ends the ser_last cycle, wrapping from 255 to 0.
REQ-023 After the last bit, the FSM SHALL enter GAP for GAP_CYCLES cycles with ser_valid=0 and ser_out=0, then return to IDLE.
REQ-024 When GAP_CYCLES=0, the FSM SHALL go directly from the last bit to IDLE.
REQ-025 Consecutive frames SHALL be separated by exactly GAP_CYCLES+1 cycles with ser_valid=0 when in_valid is held high (the GAP cycles plus one IDLE accept cycle).
REQ-026 Whenever ser_valid=0, ser_out and ser_last SHALL be 0.
REQ-027 in_valid and in_data SHALL be ignored outside IDLE; a word presented while busy=1 is neither latched nor dropped, and the source must hold it.
REQ-028 The data shift register SHALL change only on accept or during DATA; in_data changes after accept SHALL NOT affect the frame.
REQ-029 Internal bit/gap counters SHALL be sized so that no counter wraps within a frame.
REQ-030 ser_out, ser_valid and ser_last SHALL be driven from registers.
REQ-031 The transmitted stream SHALL be decodable by the team's serial "110" detector: each frame starts with a 110 preamble.

Reset
REQ-032 While reset=1 at a rising edge, the FSM SHALL go to IDLE and clear ser_out, ser_valid, ser_last, frame_cnt, the shift register and all counters to 0.
REQ-033 reset SHALL override all other inputs.
REQ-034 A reset asserted mid-frame SHALL abort the frame with no ser_last and no frame_cnt increment; ser_valid=0 from the next cycle.
REQ-035 in_ready SHALL be 1 in the first cycle after reset deasserts.

Verification
REQ-036 The bench SHALL cover: reset, then in_data=16'h0001 with in_valid pulsed -> the cycle after accept starts the ser_out sequence 1,1,0, then fifteen 0s, then 1, then parity 1 on the ser_last cycle; frame_cnt=1.
REQ-037 The bench SHALL cover: in_data=16'hA5C3, PARITY_EN=1 -> data bits 1010010111000011, parity 0, 20 ser_valid cycles, then 2 idle cycles.
REQ-038 The bench SHALL cover: in_valid held high with two words 16'hFFFF and 16'h0000 -> exactly 3 ser_valid=0 cycles between frames, and in_ready=0 throughout each frame.
REQ-039 The bench SHALL cover: reset asserted at data bit 7 of a frame -> ser_valid=0 the next cycle, frame_cnt=0, in_ready=1 after reset.
REQ-040 The bench SHALL cover: 256 frames sent back-to-back -> frame_cnt reads 255 after frame 255 and 0 after frame 256.
REQ-041 The bench SHALL cover: PARITY_EN=0, GAP_CYCLES=0 -> 19-bit frames, ser_last on data bit 0, and the next accept in the cycle after ser_last.

Source files
------------

// File: rtl/serial_pattern_tx.sv
// Serial frame transmitter: a 110 preamble, then 16 data bits MSB first, then an optional even-parity bit,
// followed by a configurable number of idle gap cycles.
module serial_pattern_tx #(
  parameter int unsigned GAP_CYCLES = 2,
  parameter int unsigned PARITY_EN  = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        ser_out,
  output logic        ser_valid,
  output logic        ser_last,
  output logic        busy,
  output logic [7:0]  frame_cnt
);

  localparam int unsigned DATA_W   = 16;
  localparam int unsigned CNT_W    = 4;
  localparam int unsigned FCNT_W   = 8;
  localparam logic [CNT_W-1:0] PRE_LAST  = CNT_W'(2);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] DATA_PEN  = CNT_W'(DATA_W - 2);
  localparam logic [CNT_W-1:0] GAP_LAST  = (GAP_CYCLES == 0) ? CNT_W'(0) : CNT_W'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, PRE, DATA, PAR, GAP} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   shreg_q, shreg_d;
  logic                par_q, par_d;
  logic                out_d, valid_d, last_d, busy_d;
  logic [FCNT_W-1:0]   fcnt_d;
  logic                frame_end;

  assign in_ready = (state_q == IDLE);

  // State and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      shreg_q   <= '0;
      par_q     <= 1'b0;
      ser_out   <= 1'b0;
      ser_valid <= 1'b0;
      ser_last  <= 1'b0;
      busy      <= 1'b0;
      frame_cnt <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      shreg_q   <= shreg_d;
      par_q     <= par_d;
      ser_out   <= out_d;
      ser_valid <= valid_d;
      ser_last  <= last_d;
      busy      <= busy_d;
      frame_cnt <= fcnt_d;
    end
  end

  // Next state; the registered outputs describe the bit shown in the following cycle
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shreg_d   = shreg_q;
    par_d     = par_q;
    out_d     = 1'b0;
    valid_d   = 1'b0;
    last_d    = 1'b0;
    fcnt_d    = frame_cnt;
    frame_end = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d = PRE;
          cnt_d   = '0;
          shreg_d = in_data;
          par_d   = ^in_data;
          out_d   = 1'b1;
          valid_d = 1'b1;
        end
      end
      PRE: begin
        valid_d = 1'b1;
        if (cnt_q == PRE_LAST) begin
          state_d = DATA;
          cnt_d   = '0;
          out_d   = shreg_q[DATA_W-1];
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          out_d = (cnt_q == '0);
        end
      end
      DATA: begin
        // shreg_q[DATA_W-1] is the bit currently on the line
        shreg_d = {shreg_q[DATA_W-2:0], 1'b0};
        if (cnt_q == DATA_LAST) begin
          if (PARITY_EN != 0) begin
            state_d = PAR;
            valid_d = 1'b1;
            out_d   = par_q;
            last_d  = 1'b1;
          end else begin
            frame_end = 1'b1;
          end
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
          valid_d = 1'b1;
          out_d   = shreg_q[DATA_W-2];
          last_d  = (PARITY_EN == 0) && (cnt_q == DATA_PEN);
        end
      end
      PAR: begin
        frame_end = 1'b1;
      end
      GAP: begin
        if (cnt_q == GAP_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (frame_end) begin
      fcnt_d  = frame_cnt + FCNT_W'(1);
      cnt_d   = '0;
      state_d = (GAP_CYCLES == 0) ? IDLE : GAP;
    end

    busy_d = (state_d != IDLE);
  end

endmodule

// File: tb/tb_serial_pattern_tx.sv
// Randomized bench for serial_pattern_tx: a frame-level reference model predicts every cycle of both
// parameterisations (parity with gap 2, and no parity with no gap).
module tb_serial_pattern_tx;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [15:0] in_data;

  logic       rdy_a, so_a, sv_a, sl_a, bz_a;
  logic [7:0] fc_a;
  logic       rdy_b, so_b, sv_b, sl_b, bz_b;
  logic [7:0] fc_b;

  always #5 clk = ~clk;

  serial_pattern_tx #(.GAP_CYCLES(2), .PARITY_EN(1)) dut_a (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(rdy_a),
    .ser_out(so_a), .ser_valid(sv_a), .ser_last(sl_a), .busy(bz_a), .frame_cnt(fc_a)
  );

  serial_pattern_tx #(.GAP_CYCLES(0), .PARITY_EN(0)) dut_b (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(rdy_b),
    .ser_out(so_b), .ser_valid(sv_b), .ser_last(sl_b), .busy(bz_b), .frame_cnt(fc_b)
  );

  int sel;
  logic       m_rdy, m_so, m_sv, m_sl, m_bz;
  logic [7:0] m_fc;
  assign m_rdy = (sel != 0) ? rdy_b : rdy_a;
  assign m_so  = (sel != 0) ? so_b  : so_a;
  assign m_sv  = (sel != 0) ? sv_b  : sv_a;
  assign m_sl  = (sel != 0) ? sl_b  : sl_a;
  assign m_bz  = (sel != 0) ? bz_b  : bz_a;
  assign m_fc  = (sel != 0) ? fc_b  : fc_a;

  // Reference model state: expected {bit,last} per frame cycle, plus busy-cycle budget
  logic [1:0] exp_q[$];
  int  busy_left;
  int  fc_m;
  int  acc_cnt;
  int  idle_run;
  int  last_gap;
  bit  rst_pending;
  bit  mon_en;
  int  checks;
  int  failures;

  function automatic int frame_len();
    return (sel != 0) ? 19 : 20;
  endfunction

  function automatic int gap_len();
    return (sel != 0) ? 0 : 2;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h cfg=%0d t=%0t", tag, got, exp, sel, $time);
    end
  endtask

  always @(negedge clk) begin : mon
    logic [1:0] e;
    logic       b;
    bit         ready_m;
    int         len;
    if (mon_en) begin
      if (rst_pending) begin
        exp_q.delete();
        busy_left = 0;
        fc_m      = 0;
      end
      rst_pending = reset;
      ready_m = (busy_left == 0);

      check("in_ready", 32'(m_rdy), 32'(ready_m));
      check("busy", 32'(m_bz), 32'(!ready_m));
      check("frame_cnt", 32'(m_fc), 32'(fc_m[7:0]));

      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("ser_valid", 32'(m_sv), 32'd1);
        check("ser_out", 32'(m_so), 32'(e[1]));
        check("ser_last", 32'(m_sl), 32'(e[0]));
        if (e[0]) fc_m = (fc_m + 1) % 256;
      end else begin
        check("idle_valid", 32'(m_sv), 32'd0);
        check("idle_out", 32'(m_so), 32'd0);
        check("idle_last", 32'(m_sl), 32'd0);
      end

      if (m_sv) begin
        if (idle_run > 0) last_gap = idle_run;
        idle_run = 0;
      end else begin
        idle_run++;
      end

      if (busy_left > 0) busy_left--;

      if (ready_m && in_valid && !reset) begin
        len = frame_len();
        for (int i = 0; i < len; i++) begin
          if (i < 3)       b = (i != 2);
          else if (i < 19) b = in_data[18-i];
          else             b = ^in_data;
          exp_q.push_back({b, 1'(i == len - 1)});
        end
        busy_left = len + gap_len();
        acc_cnt++;
      end
    end
  end

  task automatic reconfig(input int s);
    mon_en   = 1'b0;
    reset    = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    repeat (2) @(posedge clk);
    #1;
    sel = s;
    exp_q.delete();
    busy_left   = 0;
    fc_m        = 0;
    rst_pending = 1'b0;
    idle_run    = 0;
    reset       = 1'b0;
    mon_en      = 1'b1;
  endtask

  task automatic wait_acc();
    int start;
    bit seen;
    start = acc_cnt;
    seen  = 1'b0;
    for (int n = 0; n < 200 && !seen; n++) begin
      @(posedge clk);
      if (acc_cnt != start) seen = 1'b1;
    end
    #1;
    if (!seen) check("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_idle();
    bit done;
    done = 1'b0;
    for (int n = 0; n < 200 && !done; n++) begin
      @(posedge clk);
      if (busy_left == 0 && exp_q.size() == 0) done = 1'b1;
    end
    #1;
    if (!done) check("idle_timeout", 32'd0, 32'd1);
  endtask

  task automatic send(input logic [15:0] w);
    in_data  = w;
    in_valid = 1'b1;
    wait_acc();
    in_valid = 1'b0;
    in_data  = 16'(~w);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    acc_cnt  = 0;
    last_gap = 0;
    sel      = 0;
    reconfig(0);

    // Single frames with known patterns
    send(16'h0001);
    wait_idle();
    check("fc_after_0001", 32'(m_fc), 32'd1);
    send(16'hA5C3);
    wait_idle();

    // Back-to-back with in_valid held
    in_data  = 16'hFFFF;
    in_valid = 1'b1;
    wait_acc();
    in_data = 16'h0000;
    wait_acc();
    in_valid = 1'b0;
    wait_idle();
    check("b2b_gap_a", 32'(last_gap), 32'd3);

    // Reset during data bit 7
    send(16'($urandom));
    repeat (11) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_valid", 32'(m_sv), 32'd0);
    check("rst_fc", 32'(m_fc), 32'd0);
    check("rst_ready", 32'(m_rdy), 32'd1);
    @(posedge clk);
    #1;

    // Random traffic with occasional resets
    for (int c = 0; c < 800; c++) begin
      in_valid = ($urandom % 3) != 0;
      in_data  = 16'($urandom);
      reset    = ($urandom % 97) == 0;
      @(posedge clk);
      #1;
    end
    reset    = 1'b0;
    in_valid = 1'b0;
    wait_idle();

    // 256 back-to-back frames for the frame counter wrap
    #0 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 256; i++) begin
      in_data = 16'($urandom);
      wait_acc();
      if (i == 255) check("fc_255", 32'(m_fc), 32'd255);
    end
    in_valid = 1'b0;
    wait_idle();
    check("fc_wrap", 32'(m_fc), 32'd0);

    // No parity, no gap
    reconfig(1);
    send(16'h8001);
    wait_idle();
    in_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      in_data = 16'($urandom);
      wait_acc();
    end
    in_valid = 1'b0;
    wait_idle();
    check("b2b_gap_b", 32'(last_gap), 32'd1);
    check("fc_b", 32'(m_fc), 32'd7);
    for (int c = 0; c < 400; c++) begin
      in_valid = ($urandom % 2) != 0;
      in_data  = 16'($urandom);
      reset    = ($urandom % 113) == 0;
      @(posedge clk);
      #1;
    end
    reset    = 1'b0;
    in_valid = 1'b0;
    wait_idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
